hls_sram_bank: RTL

//   Memory-side responder for the HLS kernel single-port SRAM interface (address0/d0/ce0/we0/q0).

---
 rtl/hls_mem_pkg.sv | 21 ++
 rtl/hls_sram_rd_pipe.sv | 32 +++
 rtl/hls_sram_bank.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hls_mem_pkg.sv
// Shared types for the HLS kernel memory models: port tags, read pipeline stage
// layout and default widths.
package hls_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    PORT_KERNEL = 1'b0,
    PORT_HOST   = 1'b1
  } port_tag_e;

  // Default-width stage; the bank re-declares it at its own DATA_W.
  typedef struct packed {
    logic                  vld;
    port_tag_e             tag;
    logic [DATA_W_DEF-1:0] data;
  } rd_stage_t;

endpackage

// File: rtl/hls_sram_rd_pipe.sv
// Fixed-depth read-return pipeline of {vld, tag, data} stages; ap_rst empties
// every stage so no read issued before reset can complete after it.
module hls_sram_rd_pipe
  import hls_mem_pkg::*;
#(
  parameter int  STAGES  = 1,
  parameter type stage_t = rd_stage_t
) (
  input  logic   ap_clk,
  input  logic   ap_rst,
  input  stage_t stage_in,
  output stage_t stage_out
);

  stage_t pipe_q [STAGES];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign stage_out = pipe_q[STAGES-1];

endmodule

// File: rtl/hls_sram_bank.sv
// Single-port SRAM responder for an HLS kernel array with a host preload/readback
// port, configurable read latency, sticky error flags and saturating usage counters.
module hls_sram_bank
  import hls_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [ADDR_W-1:0] address0,
  input  logic              ce0,
  input  logic              we0,
  input  logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] q0,
  input  logic              host_sel,
  input  logic              host_ce,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_d,
  output logic [DATA_W-1:0] host_q,
  output logic              host_qvld,
  output logic              oor_err,
  output logic              conflict_err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("hls_sram_bank: RD_LAT must be in 1..%0d", RD_LAT_MAX);
  end

  typedef struct packed {
    logic              vld;
    port_tag_e         tag;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              act_ce;
  logic              act_we;
  logic [ADDR_W-1:0] act_addr;
  logic [DATA_W-1:0] act_d;
  port_tag_e         act_tag;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              is_rd;
  logic              is_wr;

  stage_t            stage_in;
  stage_t            stage_out;
  logic              kernel_done;
  logic              host_done;
  logic [DATA_W-1:0] q0_hold;
  logic [DATA_W-1:0] host_q_hold;

  // The owning port is the only one that reaches the array; accesses during
  // reset are ignored so nothing enters the freshly flushed pipeline.
  always_comb begin
    act_ce   = 1'b0;
    act_we   = 1'b0;
    act_addr = '0;
    act_d    = '0;
    act_tag  = PORT_KERNEL;
    if (host_sel) begin
      act_ce   = host_ce && !ap_rst;
      act_we   = host_we;
      act_addr = host_addr;
      act_d    = host_d;
      act_tag  = PORT_HOST;
    end else begin
      act_ce   = ce0 && !ap_rst;
      act_we   = we0;
      act_addr = address0;
      act_d    = d0;
      act_tag  = PORT_KERNEL;
    end
  end

  assign in_range = ({1'b0, act_addr} < DEPTH_EXT);
  assign idx      = act_addr[IDX_W-1:0];
  assign is_rd    = act_ce && !act_we;
  assign is_wr    = act_ce && act_we;

  // Array contents are deliberately not reset.
  always_ff @(posedge ap_clk) begin
    if (is_wr && in_range) begin
      mem[idx] <= act_d;
    end
  end

  always_comb begin
    stage_in      = '0;
    stage_in.vld  = is_rd;
    stage_in.tag  = act_tag;
    stage_in.data = in_range ? mem[idx] : '0;
  end

  // Read return path: a stage is valid for exactly one cycle per read and there
  // is no backpressure; the port named by tag must take the data when vld=1.
  hls_sram_rd_pipe #(
    .STAGES  (RD_LAT),
    .stage_t (stage_t)
  ) u_rd_pipe (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .stage_in  (stage_in),
    .stage_out (stage_out)
  );

  assign kernel_done = stage_out.vld && (stage_out.tag == PORT_KERNEL);
  assign host_done   = stage_out.vld && (stage_out.tag == PORT_HOST);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      q0_hold     <= '0;
      host_q_hold <= '0;
    end else begin
      if (kernel_done) q0_hold     <= stage_out.data;
      if (host_done)   host_q_hold <= stage_out.data;
    end
  end

  assign q0        = kernel_done ? stage_out.data : q0_hold;
  assign host_q    = host_done   ? stage_out.data : host_q_hold;
  assign host_qvld = host_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rd_count     <= '0;
      wr_count     <= '0;
      oor_err      <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      if (is_rd && (rd_count != 32'hFFFF_FFFF)) rd_count <= rd_count + 32'd1;
      if (is_wr && (wr_count != 32'hFFFF_FFFF)) wr_count <= wr_count + 32'd1;
      if (act_ce && !in_range)                   oor_err      <= 1'b1;
      if (ce0 && host_sel)                       conflict_err <= 1'b1;
    end
  end

endmodule
